// File: rtl/fsm_div_chain.sv
// Operand-entry FSM with a debounced centre button feeding an iterative
// restoring divider that evaluates op0/op1/.../op(N-1) with truncation toward zero.
module fsm_div_chain #(
    parameter int DATA_W         = 8,
    parameter int NUM_OPS        = 4,
    parameter int DEBOUNCE_TICKS = 32,
    localparam int IDX_W         = (NUM_OPS > 2) ? $clog2(NUM_OPS) : 1
) (
    input  logic              clk,
    input  logic              btn_reset_in,
    input  logic              btn_c_in,
    input  logic [DATA_W-1:0] SW,
    input  logic              mode_rem,
    output logic [DATA_W-1:0] disp_value,
    output logic [IDX_W-1:0]  op_idx,
    output logic              busy,
    output logic              valid_out_LED,
    output logic [1:0]        err_code
);
    localparam int CNT_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam int CYC_W = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(DATA_W + 1);
    localparam logic [IDX_W-1:0]  K_LAST    = IDX_W'(NUM_OPS - 1);
    localparam logic [IDX_W-1:0]  STEP_LAST = IDX_W'(NUM_OPS - 2);
    localparam logic [DATA_W-1:0] MIN_VAL   = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {ST_ENTRY, ST_CALC, ST_DONE, ST_ERROR} state_t;

    logic [1:0]       sync_q, sync_d;
    logic             lvl_q, lvl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    always_comb begin
        sync_d  = {sync_q[0], btn_c_in};
        lvl_d   = lvl_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync_q[1] != lvl_q) begin
            if (cnt_q == CNT_LAST) begin
                lvl_d   = sync_q[1];
                press_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  k_q, k_d, step_q, step_d;
    logic [DATA_W-1:0] op_q [NUM_OPS];
    logic [DATA_W-1:0] op_d [NUM_OPS];
    logic [DATA_W-1:0] acc_q, acc_d, quo_q, quo_d, rem_q, rem_d, dmag_q, dmag_d;
    logic              neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, mode_q, mode_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [DATA_W-1:0] disp_q, disp_d;
    logic              valid_q, valid_d;
    logic [1:0]        err_q, err_d;

    logic [IDX_W-1:0]  div_idx;
    logic [DATA_W-1:0] divisor, q_signed, r_signed;
    logic [DATA_W:0]   trial;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        step_d    = step_q;
        op_d      = op_q;
        acc_d     = acc_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dmag_d    = dmag_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        mode_d    = mode_q;
        cyc_d     = cyc_q;
        disp_d    = disp_q;
        valid_d   = valid_q;
        err_d     = err_q;
        div_idx   = step_q + 1'b1;
        divisor   = op_q[div_idx];
        trial     = {rem_q, quo_q[DATA_W-1]} - {1'b0, dmag_q};
        q_signed  = neg_quo_q ? -quo_q : quo_q;
        r_signed  = neg_rem_q ? -rem_q : rem_q;

        case (state_q)
            ST_ENTRY: begin
                if (press_q) begin
                    op_d[k_q] = SW;
                    disp_d    = SW;
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        step_d  = '0;
                        cyc_d   = '0;
                        mode_d  = mode_rem;
                        acc_d   = op_q[0];
                        state_d = ST_CALC;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            ST_CALC: begin
                if (cyc_q == '0) begin
                    // Setup: reject illegal divisions before any iteration runs.
                    if (divisor == '0) begin
                        state_d = ST_ERROR;
                        err_d   = 2'd1;
                        valid_d = 1'b1;
                        disp_d  = '0;
                    end else if (acc_q == MIN_VAL && divisor == '1) begin
                        state_d = ST_ERROR;
                        err_d   = 2'd2;
                        valid_d = 1'b1;
                        disp_d  = '0;
                    end else begin
                        quo_d     = acc_q[DATA_W-1] ? -acc_q : acc_q;
                        dmag_d    = divisor[DATA_W-1] ? -divisor : divisor;
                        rem_d     = '0;
                        neg_quo_d = acc_q[DATA_W-1] ^ divisor[DATA_W-1];
                        neg_rem_d = acc_q[DATA_W-1];
                        cyc_d     = cyc_q + 1'b1;
                    end
                end else if (cyc_q == CYC_LAST) begin
                    if (step_q == STEP_LAST) begin
                        state_d = ST_DONE;
                        valid_d = 1'b1;
                        disp_d  = mode_q ? r_signed : q_signed;
                    end else begin
                        acc_d  = q_signed;
                        step_d = step_q + 1'b1;
                        cyc_d  = '0;
                    end
                end else begin
                    // Restoring step: quo_q shifts dividend bits out and quotient bits in.
                    if (!trial[DATA_W]) begin
                        rem_d = trial[DATA_W-1:0];
                        quo_d = {quo_q[DATA_W-2:0], 1'b1};
                    end else begin
                        rem_d = {rem_q[DATA_W-2:0], quo_q[DATA_W-1]};
                        quo_d = {quo_q[DATA_W-2:0], 1'b0};
                    end
                    cyc_d = cyc_q + 1'b1;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (press_q) begin
                    state_d = ST_ENTRY;
                    k_d     = '0;
                    op_d    = '{default: '0};
                    valid_d = 1'b0;
                    err_d   = 2'd0;
                    disp_d  = '0;
                end
            end
            default: state_d = ST_ENTRY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (btn_reset_in) begin
            sync_q    <= '0;
            lvl_q     <= 1'b0;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            state_q   <= ST_ENTRY;
            k_q       <= '0;
            step_q    <= '0;
            op_q      <= '{default: '0};
            acc_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dmag_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            mode_q    <= 1'b0;
            cyc_q     <= '0;
            disp_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 2'd0;
        end else begin
            sync_q    <= sync_d;
            lvl_q     <= lvl_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            state_q   <= state_d;
            k_q       <= k_d;
            step_q    <= step_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dmag_q    <= dmag_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            mode_q    <= mode_d;
            cyc_q     <= cyc_d;
            disp_q    <= disp_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign disp_value    = disp_q;
    assign op_idx        = k_q;
    assign busy          = (state_q == ST_CALC);
    assign valid_out_LED = valid_q;
    assign err_code      = err_q;
endmodule

// File: tb/tb_fsm_div_chain.sv
// Bench for fsm_div_chain: button-driven operand entry, chained-division
// results scored against an integer-arithmetic reference model.
module tb_fsm_div_chain;
    localparam int W     = 8;
    localparam int N     = 4;
    localparam int DB    = 4;
    localparam int EXP_W = 18;

    logic         clk = 1'b0;
    logic         btn_reset_in = 1'b1;
    logic         btn_c_in = 1'b0;
    logic [W-1:0] SW = '0;
    logic         mode_rem = 1'b0;
    logic [W-1:0] disp_value;
    logic [1:0]   op_idx;
    logic         busy;
    logic         valid_out_LED;
    logic [1:0]   err_code;

    int total = 0;
    int bad   = 0;
    logic [EXP_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    fsm_div_chain #(.DATA_W(W), .NUM_OPS(N), .DEBOUNCE_TICKS(DB)) dut (
        .clk(clk), .btn_reset_in(btn_reset_in), .btn_c_in(btn_c_in), .SW(SW),
        .mode_rem(mode_rem), .disp_value(disp_value), .op_idx(op_idx),
        .busy(busy), .valid_out_LED(valid_out_LED), .err_code(err_code)
    );

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: plain signed integer division; packs {busy_cycles, err, value}.
    function automatic logic [EXP_W-1:0] model(input int o0, input int o1, input int o2,
                                                input int o3, input bit mode);
        int ops[4];
        int a, d, blen;
        logic [1:0]   e;
        logic [W-1:0] v;
        ops = '{o0, o1, o2, o3};
        a = ops[0];
        e = 2'd0;
        blen = (N - 1) * (W + 2);
        for (int i = 1; i < N; i++) begin
            d = ops[i];
            if (d == 0) begin
                e = 2'd1; blen = (i - 1) * (W + 2) + 1; break;
            end
            if (a == -128 && d == -1) begin
                e = 2'd2; blen = (i - 1) * (W + 2) + 1; break;
            end
            if (i == N - 1 && mode) a = a % d;
            else a = a / d;
        end
        v = (e != 2'd0) ? '0 : W'(a);
        return {8'(blen), e, v};
    endfunction

    // Monitor: pops an expectation on every rising edge of valid_out_LED.
    logic prev_valid = 1'b0;
    logic prev_busy  = 1'b0;
    int   busy_cnt   = 0;
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (btn_reset_in) begin
            busy_cnt   = 0;
            prev_valid = 1'b0;
            prev_busy  = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (valid_out_LED && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_valid actual=1 required=0");
                end else begin
                    e = exp_q.pop_front();
                    check("result", int'(disp_value), int'(e[W-1:0]));
                    check("err_code", int'(err_code), int'(e[W+1:W]));
                    check("busy_cycles", busy_cnt, int'(e[EXP_W-1:W+2]));
                    check("valid_after_busy", int'(prev_busy), 1);
                    check("busy_in_done", int'(busy), 0);
                end
                busy_cnt = 0;
            end
            prev_valid = valid_out_LED;
            prev_busy  = busy;
        end
    end

    task automatic press();
        btn_c_in = 1'b1;
        repeat (DB + 4) @(posedge clk);
        #1;
        btn_c_in = 1'b0;
        repeat (DB + 4) @(posedge clk);
        #1;
    endtask

    task automatic enter_ops(input int o0, input int o1, input int o2, input int o3,
                             input bit mode, input bit push);
        int ops[4];
        ops = '{o0, o1, o2, o3};
        for (int i = 0; i < N; i++) begin
            check("op_idx_entry", int'(op_idx), i);
            SW = W'(ops[i]);
            if (i == N - 1) begin
                mode_rem = mode;
                if (push) exp_q.push_back(model(o0, o1, o2, o3, mode));
            end
            press();
            if (i < N - 1) check("disp_entry", int'(disp_value), ops[i] & 255);
        end
        SW = W'($urandom);
        mode_rem = 1'($urandom);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!valid_out_LED && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!valid_out_LED) begin
            total++; bad++;
            $display("FAIL valid_timeout actual=0 required=1");
        end
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_press();
        press();
        check("clr_valid", int'(valid_out_LED), 0);
        check("clr_err", int'(err_code), 0);
        check("clr_disp", int'(disp_value), 0);
        check("clr_op_idx", int'(op_idx), 0);
        check("clr_busy", int'(busy), 0);
    endtask

    task automatic run(input int o0, input int o1, input int o2, input int o3, input bit mode);
        enter_ops(o0, o1, o2, o3, mode, 1'b1);
        wait_valid();
        clear_press();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b, c, d, glen;
        repeat (3) @(posedge clk);
        #1;
        btn_reset_in = 1'b0;
        @(negedge clk);
        check("rst_disp", int'(disp_value), 0);
        check("rst_op_idx", int'(op_idx), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(valid_out_LED), 0);
        check("rst_err", int'(err_code), 0);
        @(posedge clk);
        #1;

        run(100, 5, 2, 3, 1'b0);
        run(100, 5, 2, 3, 1'b1);
        run(-100, 1, 1, 7, 1'b0);
        run(-100, 1, 1, 7, 1'b1);
        run(3, 0, 2, 1, 1'b0);
        run(-128, -1, 1, 1, 1'b0);
        run(-128, 1, 3, -5, 1'b1);

        // Short glitches must never be accepted as presses.
        SW = 8'h55;
        for (int g = 0; g < 9; g++) begin
            glen = (g % 3) + 1;
            btn_c_in = 1'b1;
            repeat (glen) @(posedge clk);
            #1;
            btn_c_in = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        repeat (DB + 4) @(posedge clk);
        #1;
        check("glitch_op_idx", int'(op_idx), 0);
        check("glitch_disp", int'(disp_value), 0);

        // Press during CALC is ignored.
        enter_ops(100, 5, 2, 3, 1'b0, 1'b1);
        press();
        wait_valid();
        repeat (5) @(posedge clk);
        #1;
        check("calc_press_valid", int'(valid_out_LED), 1);
        check("calc_press_disp", int'(disp_value), 3);
        clear_press();

        // Reset mid-CALC aborts with no result.
        enter_ops(77, 3, 2, 1, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        btn_reset_in = 1'b1;
        @(posedge clk);
        #1;
        btn_reset_in = 1'b0;
        check("abort_disp", int'(disp_value), 0);
        check("abort_op_idx", int'(op_idx), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(valid_out_LED), 0);
        check("abort_err", int'(err_code), 0);
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_result", int'(valid_out_LED), 0);

        for (int r = 0; r < 20; r++) begin
            a = int'($urandom_range(0, 255)) - 128;
            b = int'($urandom_range(0, 8)) - 4;
            c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) - 128
                                            : int'($urandom_range(0, 8)) - 4;
            d = int'($urandom_range(0, 8)) - 4;
            run(a, b, c, d, 1'($urandom));
        end

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fsm_div_chain.md
Name: fsm_div_chain

Overview:
- Parametrised successor of the single-pair divide top: an operand-entry FSM plus an iterative signed divider.
- Collects NUM_OPS signed operands from the switches, one per debounced press of the centre button.
- Computes a chained truncating division op0/op1/…/op(N-1), with optional remainder of the final step.
- Reports result, valid and error code to the existing 7-segment display mux and LEDs.

Parameters:
- DATA_W, 8: operand/result width, signed two's complement, ≥2.
- NUM_OPS, 4: operands collected per calculation, ≥2.
- DEBOUNCE_TICKS, 32: consecutive stable clk cycles required to accept a button level change, ≥1.

Ports:
- clk  in  1  system clock.
- btn_reset_in  in  1  synchronous active-high reset.
- btn_c_in  in  1  raw centre button (asynchronous; 2-FF synchronised internally).
- SW  in  DATA_W  signed operand switches.
- mode_rem  in  1  0: quotient, 1: remainder of final step.
- disp_value  out  DATA_W  value for display mux.
- op_idx  out  max(1,$clog2(NUM_OPS))  index of next operand to enter.
- busy  out  1  high while calculating.
- valid_out_LED  out  1  calculation finished (DONE or ERROR).
- err_code  out  2  0 none, 1 divide-by-zero, 2 overflow.

Behaviour:
- Reset (synchronous, active-high, has priority on the same edge): all outputs 0; FSM in ENTRY with k=0; operand regs 0; debouncer state low, counter 0.
- Reset mid-CALC aborts the calculation; no partial result is kept.
- Debounce: synchronised level must differ from the accepted level for DEBOUNCE_TICKS consecutive cycles before the accepted level flips.
  - Any bounce restarts the count.
  - The press pulse is 1 cycle on the accepted rising edge.
  - Release is debounced the same way.
- ENTRY: on a press, SW is latched into op[k], disp_value=SW and k increments.
  - Capture of op[NUM_OPS-1] moves to CALC on the next cycle.
  - mode_rem is sampled at that same moment.
  - op_idx = k.
- CALC: busy=1. Acc starts as op0. NUM_OPS-1 steps run; each step takes exactly DATA_W+2 cycles:
  - 1 setup cycle: divisor zero check, overflow check, magnitudes taken.
  - DATA_W restoring iterations.
  - 1 sign-fix cycle.
- Division rules: truncation toward zero; remainder carries the dividend's sign. Intermediate steps always pass the quotient forward; the final step outputs the remainder if mode_rem=1.
- Zero divisor detected in setup: go to ERROR next cycle with err_code=1. Dividend −2^(DATA_W−1) with divisor −1: ERROR with err_code=2. Remaining steps are skipped.
- Latency: valid_out_LED rises exactly (NUM_OPS−1)(DATA_W+2)+1 cycles after the press pulse that captured the last operand, when no error occurs.
- DONE: valid_out_LED=1, busy=0, err_code=0, disp_value=result held.
- ERROR: valid_out_LED=1, busy=0, disp_value=0, err_code held.
- Press in DONE or ERROR: clears valid, err_code, disp_value and all op regs; returns to ENTRY with k=0. The same press does not capture an operand.
- Presses during CALC are ignored (not queued). SW changes outside a press pulse have no effect.

Test Plan (DATA_W=8, NUM_OPS=4, DEBOUNCE_TICKS=4):
1. Enter 100,5,2,3, mode_rem=0 → busy for 30 cycles; valid_out_LED=1 at 31 cycles after the last press pulse; disp_value=3; err_code=0; op_idx during entry steps 0,1,2,3.
2. Same operands, mode_rem=1 → disp_value=1 (10 rem 3); press again → valid=0, disp_value=0, op_idx=0.
3. Enter −100,1,1,7 → quotient disp_value=0xF2 (−14); with mode_rem=1 → 0xFE (−2).
4. Enter 3,0,2,1 → ERROR at step 1 after setup; err_code=1, valid_out_LED=1, disp_value=0; press → ENTRY, err_code=0.
5. Enter −128,−1,1,1 → err_code=2, valid_out_LED=1, disp_value=0.
6. btn_c_in glitches of 1–3 cycles → no capture, op_idx unchanged.
   - Press during CALC → ignored, result unchanged.
   - btn_reset_in pulsed mid-CALC → next cycle all outputs 0, op_idx=0, ENTRY.
